// File: rtl/alu_cmd_frontend.sv
// Byte-stream command front end: assembles header + operand frames and issues one
// registered single-cycle enable per complete frame to the matching ALU unit.
module alu_cmd_frontend #(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clock,
  input  logic             rest,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [3:0]       ALU_FUN,
  output logic             Arith_enble,
  output logic             Logic_enble,
  output logic             CMP_enble,
  output logic             Shift_enble,
  output logic             cmd_done,
  output logic             frame_err
);

  localparam int unsigned N       = WIDTH / 8;
  localparam int unsigned IdxW    = (N > 1) ? $clog2(N) : 1;
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(N - 1);
  // Timeout fires on the idle cycle that would bring the counter to TIMEOUT.
  localparam logic [15:0]     TimeoutLast = 16'(TIMEOUT - 1);

  typedef enum logic [2:0] {StIdle, StOpa, StOpb, StIssue, StWait} state_e;

  state_e           state_q, state_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [15:0]      tcnt_q, tcnt_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic [3:0]       sh_fun_q, sh_fun_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [3:0]       fun_q, fun_d;
  logic [3:0]       en_q, en_d;
  logic             cmd_done_q, cmd_done_d;
  logic             frame_err_q, frame_err_d;
  logic             rx_open;
  logic             xfer;

  assign rx_open  = (state_q == StIdle) || (state_q == StOpa) || (state_q == StOpb);
  assign rx_ready = rx_open && !rest;
  assign xfer     = rx_valid && rx_open;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tcnt_d      = tcnt_q;
    sh_a_d      = sh_a_q;
    sh_b_d      = sh_b_q;
    sh_fun_d    = sh_fun_q;
    a_d         = a_q;
    b_d         = b_q;
    fun_d       = fun_q;
    en_d        = 4'b0000;
    cmd_done_d  = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (xfer) begin
          if (rx_data[7:4] == 4'hA) begin
            sh_fun_d = rx_data[3:0];
            idx_d    = '0;
            tcnt_d   = '0;
            state_d  = StOpa;
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
      StOpa: begin
        if (xfer) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) sh_a_d[8*i +: 8] = rx_data;
          end
          tcnt_d = '0;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StOpb;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tcnt_q == TimeoutLast) begin
          tcnt_d      = '0;
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StOpb: begin
        if (xfer) begin
          for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IdxW'(i)) sh_b_d[8*i +: 8] = rx_data;
          end
          tcnt_d = '0;
          if (idx_q == IdxLast) begin
            idx_d   = '0;
            state_d = StIssue;
            // Outputs and the enable are registered on the edge entering ISSUE.
            a_d     = sh_a_q;
            b_d     = sh_b_d;
            fun_d   = sh_fun_q;
            en_d    = 4'b0001 << sh_fun_q[3:2];
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if (tcnt_q == TimeoutLast) begin
          tcnt_d      = '0;
          frame_err_d = 1'b1;
          state_d     = StIdle;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
        end
      end
      StIssue: begin
        cmd_done_d = 1'b1;
        state_d    = StWait;
      end
      StWait: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (rest) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      tcnt_q      <= '0;
      sh_a_q      <= '0;
      sh_b_q      <= '0;
      sh_fun_q    <= '0;
      a_q         <= '0;
      b_q         <= '0;
      fun_q       <= '0;
      en_q        <= '0;
      cmd_done_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tcnt_q      <= tcnt_d;
      sh_a_q      <= sh_a_d;
      sh_b_q      <= sh_b_d;
      sh_fun_q    <= sh_fun_d;
      a_q         <= a_d;
      b_q         <= b_d;
      fun_q       <= fun_d;
      en_q        <= en_d;
      cmd_done_q  <= cmd_done_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign A           = a_q;
  assign B           = b_q;
  assign ALU_FUN     = fun_q;
  assign Arith_enble = en_q[0];
  assign Logic_enble = en_q[1];
  assign CMP_enble   = en_q[2];
  assign Shift_enble = en_q[3];
  assign cmd_done    = cmd_done_q;
  assign frame_err   = frame_err_q;

endmodule

// File: tb/tb_alu_cmd_frontend.sv
// Scoreboard bench for alu_cmd_frontend: the driver queues expected issues and frame
// errors, a negedge monitor pops and compares whenever the DUT presents a result.
module tb_alu_cmd_frontend;

  logic        clock = 1'b0;
  logic        rest  = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [15:0] A, B;
  logic [3:0]  ALU_FUN;
  logic        Arith_enble, Logic_enble, CMP_enble, Shift_enble;
  logic        cmd_done, frame_err;

  alu_cmd_frontend #(.WIDTH(16), .TIMEOUT(8)) dut (
    .clock       (clock),
    .rest        (rest),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .A           (A),
    .B           (B),
    .ALU_FUN     (ALU_FUN),
    .Arith_enble (Arith_enble),
    .Logic_enble (Logic_enble),
    .CMP_enble   (CMP_enble),
    .Shift_enble (Shift_enble),
    .cmd_done    (cmd_done),
    .frame_err   (frame_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_err;
    logic [3:0]  en;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  fun;
    int          hdr_cyc;
    bit          lat;
  } exp_t;

  exp_t        sb[$];
  int          nvec = 0;
  int          nerr = 0;
  int          cyc  = 0;
  int          last_cyc = 0;
  logic [15:0] last_a = '0, last_b = '0;
  logic [3:0]  last_fun = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Offer one byte from posedge+1 and hold it until accepted (bounded).
  task automatic send_byte(input logic [7:0] b);
    int k = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clock);
    while (!rx_ready && k < 20) begin
      @(negedge clock);
      k++;
    end
    if (!rx_ready) chk("byte_accept_bound", 32'(rx_ready), 32'd1);
    last_cyc = cyc;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic gap(input int n);
    rx_valid = 1'b0;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1; e.en = '0; e.a = '0; e.b = '0; e.fun = '0; e.hdr_cyc = 0; e.lat = 1'b0;
    sb.push_back(e);
  endtask

  task automatic push_issue(input logic [7:0] hdr, input logic [15:0] a, input logic [15:0] b,
                            input bit lat);
    exp_t e;
    e.is_err = 1'b0; e.en = 4'b0001 << hdr[3:2]; e.a = a; e.b = b; e.fun = hdr[3:0];
    e.hdr_cyc = last_cyc; e.lat = lat;
    sb.push_back(e);
    last_a = a; last_b = b; last_fun = hdr[3:0];
  endtask

  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] a, input logic [15:0] b,
                            input int maxgap);
    logic [7:0] bytes [4];
    bytes = '{a[7:0], a[15:8], b[7:0], b[15:8]};
    send_byte(hdr);
    push_issue(hdr, a, b, maxgap == 0);
    for (int i = 0; i < 4; i++) begin
      if (maxgap > 0) gap($urandom_range(0, maxgap));
      send_byte(bytes[i]);
    end
  endtask

  task automatic chk_hold(input string nm);
    chk({nm, "_A"}, 32'(A), 32'(last_a));
    chk({nm, "_B"}, 32'(B), 32'(last_b));
    chk({nm, "_FUN"}, 32'(ALU_FUN), 32'(last_fun));
  endtask

  // Monitor: compares every enable, cmd_done and frame_err against the queue.
  bit          done_due = 1'b0;
  bit          due_lat  = 1'b0;
  int          due_hdr  = 0;
  logic [3:0]  en_v;
  exp_t        m;

  always @(negedge clock) begin
    en_v = {Shift_enble, CMP_enble, Logic_enble, Arith_enble};
    if (rest) begin
      done_due = 1'b0;
    end else begin
      if (frame_err && cmd_done) begin
        nerr++;
        $display("FAIL err_done_overlap: frame_err and cmd_done both 1 (cycle %0d)", cyc);
      end
      if (done_due) begin
        chk("cmd_done", 32'(cmd_done), 32'd1);
        chk("rx_ready_wait", 32'(rx_ready), 32'd0);
        if (due_lat) chk("latency", 32'(cyc - due_hdr), 32'd6);
        done_due = 1'b0;
      end else if (cmd_done) begin
        nerr++;
        $display("FAIL stray_cmd_done: got 1 expected 0 (cycle %0d)", cyc);
      end
      if (en_v != 4'b0000) begin
        if (sb.size() == 0 || sb[0].is_err) begin
          nerr++;
          $display("FAIL unexpected_enable: got %b expected none (cycle %0d)", en_v, cyc);
        end else begin
          m = sb.pop_front();
          chk("enable", 32'(en_v), 32'(m.en));
          chk("A", 32'(A), 32'(m.a));
          chk("B", 32'(B), 32'(m.b));
          chk("ALU_FUN", 32'(ALU_FUN), 32'(m.fun));
          chk("rx_ready_issue", 32'(rx_ready), 32'd0);
          done_due = 1'b1;
          due_lat  = m.lat;
          due_hdr  = m.hdr_cyc;
        end
      end
      if (frame_err) begin
        if (sb.size() == 0 || !sb[0].is_err) begin
          nerr++;
          $display("FAIL unexpected_frame_err: got 1 expected 0 (cycle %0d)", cyc);
        end else begin
          m = sb.pop_front();
          nvec++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while rest is held.
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_rx_ready", 32'(rx_ready), 32'd0);
    chk("reset_A", 32'(A), 32'd0);
    chk("reset_en", 32'({Shift_enble, CMP_enble, Logic_enble, Arith_enble}), 32'd0);
    @(posedge clock);
    #1;
    rest = 1'b0;
    @(negedge clock);
    chk("post_reset_rx_ready", 32'(rx_ready), 32'd1);
    chk("post_reset_B", 32'(B), 32'd0);
    chk("post_reset_FUN", 32'(ALU_FUN), 32'd0);
    chk("post_reset_flags", 32'({cmd_done, frame_err}), 32'd0);
    @(posedge clock);
    #1;

    // Single frame, header A2 (function 2 decodes to the arithmetic unit).
    send_frame(8'hA2, 16'h1234, 16'h1234, 0);

    // Enable decode on ALU_FUN[3:2], frames back to back.
    send_frame(8'hA0, 16'h0001, 16'h0002, 0);
    send_frame(8'hA5, 16'hA5A5, 16'h5A5A, 0);
    send_frame(8'hA9, 16'h00FF, 16'hFF00, 0);
    send_frame(8'hAF, 16'h8001, 16'h0004, 0);
    gap(3);

    // Bad header: one frame_err, outputs untouched, next frame issues normally.
    push_err();
    send_byte(8'h5B);
    gap(3);
    chk_hold("bad_hdr_hold");
    send_frame(8'hA3, 16'h0005, 16'h0003, 0);

    // Gaps inside frames (all shorter than TIMEOUT=8).
    send_frame(8'hAD, 16'hBEEF, 16'h1357, 5);
    send_frame(8'hA6, 16'hC0DE, 16'h2468, 7);
    send_frame(8'hAB, 16'h0F0F, 16'hF0F0, 3);
    gap(3);

    // Timeout: 8 idle cycles abort the frame, 7 do not.
    send_byte(8'hA1);
    push_err();
    send_byte(8'hFF);
    gap(8);
    gap(3);
    chk_hold("timeout_hold");
    send_byte(8'hA1);
    push_issue(8'hA1, 16'h01FF, 16'h0077, 1'b0);
    send_byte(8'hFF);
    gap(7);
    send_byte(8'h01);
    send_byte(8'h77);
    send_byte(8'h00);
    gap(3);

    // Reset during OPB: partial frame discarded, outputs cleared.
    send_byte(8'hA4);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    rest = 1'b1;
    @(negedge clock);
    chk("mid_reset_rx_ready", 32'(rx_ready), 32'd0);
    @(posedge clock);
    #1;
    rest = 1'b0;
    last_a = '0; last_b = '0; last_fun = '0;
    @(negedge clock);
    chk("mid_reset_rx_ready_after", 32'(rx_ready), 32'd1);
    chk_hold("mid_reset_clear");
    @(posedge clock);
    #1;
    send_frame(8'hA6, 16'h5544, 16'h7766, 0);
    gap(6);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
